// File: rtl/b2aik.sv
// Registered BCD-to-Aiken (2421) converter with per-digit invalid flags and a
// saturating count of words that carried at least one non-BCD nibble.
module b2aik #(
  parameter int DIGITS = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4*DIGITS-1:0]   bin,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   aiken,
  output logic                  invalid,
  output logic [DIGITS-1:0]     invalid_digits,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Digits 5..9 are the bitwise complement of 4..0, giving the self-complementing code.
  function automatic logic [3:0] to_aiken(input logic [3:0] d);
    case (d)
      4'd0:    to_aiken = 4'b0000;
      4'd1:    to_aiken = 4'b0001;
      4'd2:    to_aiken = 4'b0010;
      4'd3:    to_aiken = 4'b0011;
      4'd4:    to_aiken = 4'b0100;
      4'd5:    to_aiken = 4'b1011;
      4'd6:    to_aiken = 4'b1100;
      4'd7:    to_aiken = 4'b1101;
      4'd8:    to_aiken = 4'b1110;
      4'd9:    to_aiken = 4'b1111;
      default: to_aiken = 4'b0000;
    endcase
  endfunction

  logic [4*DIGITS-1:0] aiken_d;
  logic [DIGITS-1:0]   inv_d;

  always_comb begin
    // NOTE: defaults assigned first so no path leaves a variable unassigned (no latch).
    aiken_d = '0;
    inv_d   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      aiken_d[4*k +: 4] = to_aiken(bin[4*k +: 4]);
      inv_d[k]          = (bin[4*k +: 4] > 4'd9);
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      aiken          <= '0;
      invalid        <= 1'b0;
      invalid_digits <= '0;
      err_cnt        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        aiken          <= aiken_d;
        invalid_digits <= inv_d;
        invalid        <= |inv_d;
        if (|inv_d && err_cnt != CNT_MAX)
          err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_b2aik.sv
// Directed bench for b2aik: three instances cover 1-digit, 2-digit and a
// 2-bit saturating counter configuration sharing one clock and reset.
module tb_b2aik;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // 1-digit, 8-bit counter
  logic       v1 = 1'b0;
  logic [3:0] b1 = '0;
  logic       ov1, inv1;
  logic [3:0] ak1;
  logic [0:0] id1;
  logic [7:0] ec1;

  // 2-digit
  logic       v2 = 1'b0;
  logic [7:0] b2 = '0;
  logic       ov2, inv2;
  logic [7:0] ak2;
  logic [1:0] id2;
  logic [7:0] ec2;

  // 1-digit, 2-bit counter
  logic       v3 = 1'b0;
  logic [3:0] b3 = '0;
  logic       ov3, inv3;
  logic [3:0] ak3;
  logic [0:0] id3;
  logic [1:0] ec3;

  b2aik #(.DIGITS(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .bin(b1), .out_valid(ov1),
    .aiken(ak1), .invalid(inv1), .invalid_digits(id1), .err_cnt(ec1));

  b2aik #(.DIGITS(2), .CNT_W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .bin(b2), .out_valid(ov2),
    .aiken(ak2), .invalid(inv2), .invalid_digits(id2), .err_cnt(ec2));

  b2aik #(.DIGITS(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .bin(b3), .out_valid(ov3),
    .aiken(ak3), .invalid(inv3), .invalid_digits(id3), .err_cnt(ec3));

  // Hand-written Aiken table, index = BCD digit (10..15 -> 0000)
  logic [3:0] exp_tab [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                               4'b0100, 4'b1011, 4'b1100, 4'b1101,
                               4'b1110, 4'b1111, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] obs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_total++;
    if ({ov1, ak1, inv1, id1, ec1} !== '0) begin
      $display("FAIL reset_d1: got %h want 0", {ov1, ak1, inv1, id1, ec1});
    end else n_pass++;
    n_total++;
    if ({ov2, ak2, inv2, id2, ec2, ov3, ec3} !== '0) begin
      $display("FAIL reset_d2_sat: got %h want 0", {ov2, ak2, inv2, id2, ec2, ov3, ec3});
    end else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_total++;
    if ({ov1, ak1, inv1, id1, ec1} !== '0) begin
      $display("FAIL reset_idle: got %h want 0", {ov1, ak1, inv1, id1, ec1});
    end else n_pass++;
  endtask

  task automatic test_sweep();
    for (int d = 0; d < 16; d++) begin
      v1 = 1'b1;
      b1 = 4'(d);
      tick();
      n_total++;
      if (ov1 !== 1'b1 || ak1 !== exp_tab[d] || inv1 !== (d > 9) || id1 !== 1'((d > 9))) begin
        $display("FAIL sweep_%0d: got ov=%b aiken=%b inv=%b id=%b want ov=1 aiken=%b inv=%b",
                 d, ov1, ak1, inv1, id1, exp_tab[d], (d > 9));
      end else n_pass++;
      if (d < 10) obs[d] = ak1;
    end
    v1 = 1'b0;
    tick();
    n_total++;
    if (ec1 !== 8'd6 || ov1 !== 1'b0) begin
      $display("FAIL sweep_err_cnt: got cnt=%0d ov=%b want cnt=6 ov=0", ec1, ov1);
    end else n_pass++;
  endtask

  task automatic test_self_complement();
    int wsum;
    for (int d = 0; d < 10; d++) begin
      n_total++;
      if ((obs[d] ^ obs[9-d]) !== 4'b1111) begin
        $display("FAIL complement_%0d: got %b^%b want 1111", d, obs[d], obs[9-d]);
      end else n_pass++;
      wsum = 2*obs[d][3] + 4*obs[d][2] + 2*obs[d][1] + obs[d][0];
      n_total++;
      if (wsum != d) begin
        $display("FAIL weight_%0d: got sum %0d want %0d", d, wsum, d);
      end else n_pass++;
    end
  endtask

  task automatic test_two_digit();
    v2 = 1'b1;
    b2 = 8'h5C;
    tick();
    n_total++;
    if (ak2 !== 8'b1011_0000 || id2 !== 2'b01 || inv2 !== 1'b1 || ov2 !== 1'b1) begin
      $display("FAIL d2_5C: got aiken=%b id=%b inv=%b ov=%b want 10110000 01 1 1",
               ak2, id2, inv2, ov2);
    end else n_pass++;
    b2 = 8'h97;
    tick();
    n_total++;
    if (ak2 !== 8'b1111_1101 || id2 !== 2'b00 || inv2 !== 1'b0 || ov2 !== 1'b1) begin
      $display("FAIL d2_97: got aiken=%b id=%b inv=%b ov=%b want 11111101 00 0 1",
               ak2, id2, inv2, ov2);
    end else n_pass++;
    v2 = 1'b0;
    tick();
    n_total++;
    if (ec2 !== 8'd1 || ov2 !== 1'b0 || ak2 !== 8'b1111_1101) begin
      $display("FAIL d2_hold: got cnt=%0d ov=%b aiken=%b want 1 0 11111101", ec2, ov2, ak2);
    end else n_pass++;
  endtask

  task automatic test_handshake();
    logic       pv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] pb [4] = '{4'd3, 4'd9, 4'd5, 4'd8};
    logic [3:0] ea [4] = '{4'b0011, 4'b0011, 4'b1011, 4'b1110};
    n_total++;
    if (ov1 !== 1'b0) begin
      $display("FAIL hs_pre: got ov=%b want 0", ov1);
    end else n_pass++;
    for (int i = 0; i < 4; i++) begin
      v1 = pv[i];
      b1 = pb[i];
      tick();
      n_total++;
      if (ov1 !== pv[i] || ak1 !== ea[i]) begin
        $display("FAIL hs_%0d: got ov=%b aiken=%b want ov=%b aiken=%b", i, ov1, ak1, pv[i], ea[i]);
      end else n_pass++;
    end
    v1 = 1'b0;
    tick();
    n_total++;
    if (ov1 !== 1'b0 || ak1 !== 4'b1110) begin
      $display("FAIL hs_end: got ov=%b aiken=%b want 0 1110", ov1, ak1);
    end else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] ec_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    v3 = 1'b1;
    b3 = 4'hA;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (ec3 !== ec_exp[i] || inv3 !== 1'b1) begin
        $display("FAIL sat_%0d: got cnt=%0d inv=%b want cnt=%0d inv=1", i, ec3, inv3, ec_exp[i]);
      end else n_pass++;
    end
    // Mid-stream reset: in-flight words on both instances are discarded.
    v1 = 1'b1;
    b1 = 4'd7;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ec3 !== 2'd0 || ov3 !== 1'b0 || inv3 !== 1'b0) begin
      $display("FAIL sat_reset: got cnt=%0d ov=%b inv=%b want 0 0 0", ec3, ov3, inv3);
    end else n_pass++;
    n_total++;
    if ({ov1, ak1, inv1, id1, ec1} !== '0) begin
      $display("FAIL midstream_reset: got %h want 0", {ov1, ak1, inv1, id1, ec1});
    end else n_pass++;
    tick();
    n_total++;
    if ({ov1, ak1, ec3} !== '0) begin
      $display("FAIL reset_held: got %h want 0", {ov1, ak1, ec3});
    end else n_pass++;
    v1 = 1'b0;
    v3 = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_self_complement();
    test_two_digit();
    test_handshake();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
